neuron_layer: RTL and testbench
===============================

# neuron_layer

Parametrised successor to the single-lane neuron. One shared pixel stream drives NUM_NEURONS parallel multiply-accumulate lanes, each with its own signed weight and bias. A start/valid-ready sequencer counts exactly N_INPUTS accepted beats, then applies saturation and optional ReLU. The block presents one registered result vector per inference to the neural core's output stage through a valid/ready handshake.

## Interface
- NUM_NEURONS, 4: parallel lanes, ≥1.
- N_INPUTS, 49: pixel/weight beats per inference, ≥1.
- W_WEIGHT, 32: signed weight width.
- W_PIXEL, 8: unsigned pixel width.
- W_ACC, 32: signed accumulator, bias and result width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin an inference; sampled only in IDLE.
- bias_in  in  NUM_NEURONS*W_ACC  per-lane signed bias, lane i at [i*W_ACC +: W_ACC]; sampled on an accepted start.
- relu_en  in  1  ReLU enable; sampled on an accepted start.
- in_valid  in  1  pixel/weights beat valid.
- in_ready  out  1  block accepts a beat.
- pixel  in  W_PIXEL  unsigned pixel, shared by all lanes.
- weights  in  NUM_NEURONS*W_WEIGHT  per-lane signed weight.
- out_valid  out  1  sigma holds a finished result.
- out_ready  in  1  consumer accepts the result.
- sigma  out  NUM_NEURONS*W_ACC  per-lane signed result.
- sat_flag  out  NUM_NEURONS  sticky per-lane saturation flag for the current or last inference.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, RESULT.
- **IDLE**
  - start=1: acc[i] loads bias_in[i], beat counter clears to 0, sat_flag clears, relu_en is latched; next state is ACCUM.
  - start=0: the block stays in IDLE.
- **ACCUM**
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - Per accepted beat: acc[i] ← sat(acc[i] + weights[i]·pixel); counter increments.
  - Saturation clamps to [-2^(W_ACC-1), 2^(W_ACC-1)-1].
  - Arithmetic: pixel is zero-extended to W_PIXEL+1 signed bits. The product is exact at W_WEIGHT+W_PIXEL+1 bits. The sum is formed at full width, then clamped.
  - Any clamp sets sat_flag[i] sticky.
  - On the beat accepted when the counter equals N_INPUTS-1: sigma[i] ← relu ? max(final,0) : final, using the saturated final sum. Next state is RESULT.
- **RESULT**
  - out_valid=1; sigma is stable.
  - out_ready=1 completes the handshake; next state is IDLE.
- Ignored inputs:
  - start outside IDLE, including in the cycle the RESULT handshake completes.
  - in_valid outside ACCUM.
- sigma and sat_flag hold their values after the handshake until the next result or next start respectively.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, sigma=0, sat_flag=0, acc=0, counter=0, state=IDLE.
- rst asserted at any time, including mid-ACCUM or mid-RESULT, forces the reset values immediately without waiting for a clock edge. No partial result survives.
- Latencies:
  - start accepted at edge t → in_ready=1 from t+1.
  - Last beat accepted at edge t → out_valid=1 and sigma valid from t+1.
  - out_ready handshake at edge t → IDLE from t+1; a start at t+1 is accepted.
- Throughput: at most 1 beat per cycle. Minimum inference time is N_INPUTS+2 cycles from start to IDLE when in_valid and out_ready are held high.
- in_ready is a registered state decode, with no combinational path from in_valid.
- out_valid has no combinational path from out_ready.

## Structure
- Package neuron_pkg holds:
  - the state enum type;
  - the saturation bound constants, as functions of W_ACC;
  - a sat_add function.
- Sub-module neuron_mac_lane, instantiated NUM_NEURONS times by generate. Each lane contains:
  - the accumulator register;
  - the full-width product and sum;
  - the clamp, the sticky sat flag and ReLU;
  - the sigma register.
- The top level contains only the FSM, the beat counter and the handshakes.

## Test plan
- Basic sum (defaults, relu_en=0): bias={10,-5,0,100}, pixel=1 every beat, weights={1,2,-1,0}, 49 back-to-back beats → sigma={59,93,-49,100}; out_valid exactly 1 cycle after the 49th handshake; sat_flag=0.
- ReLU: same stimulus with relu_en=1 → sigma={59,93,0,100}.
- Positive saturation: bias=0x7FFF_FF00, pixel=255, weight=0x7FFF_FFFF → sigma=0x7FFF_FFFF, sat_flag=1.
- Negative saturation: bias=0x8000_0100, weight=0x8000_0000 → sigma=0x8000_0000, sat_flag=1.
- Flow control:
  - Random in_valid gaps → result identical to the back-to-back run.
  - in_valid pulses in IDLE and RESULT → no effect.
  - out_ready held low for 10 cycles → sigma and out_valid stable throughout.
  - start pulses while busy → ignored.
- Reset mid-inference: rst at beat 20 → all outputs 0 before the next edge; a fresh run of the basic-sum case afterwards → {59,93,-49,100}, with no residue from the interrupted run.
- Back-to-back inferences: start issued the cycle after the handshake → accepted; second result correct; sat_flag reflects only the second run.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron layer.
//   state_e  : sequencer states (IDLE / ACCUM / RESULT)
//   acc_max  : largest signed value representable in w_acc bits
//   acc_min  : smallest signed value representable in w_acc bits
//   sat_add  : wide signed add followed by a clamp to the w_acc range
package neuron_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_RESULT
  } state_e;

  // Working width for saturating arithmetic; must exceed W_WEIGHT+W_PIXEL+2.
  localparam int unsigned SAT_W = 128;

  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic wide_t acc_max(input int unsigned w_acc);
    wide_t one;
    one = wide_t'(1);
    return (one <<< (w_acc - 1)) - one;
  endfunction

  function automatic wide_t acc_min(input int unsigned w_acc);
    wide_t one;
    one = wide_t'(1);
    return -(one <<< (w_acc - 1));
  endfunction

  // Exact sum of a and b, clamped to the w_acc signed range; sat reports a clamp.
  function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                    input int unsigned w_acc, output logic sat);
    wide_t sum;
    wide_t hi;
    wide_t lo;
    sum = a + b;
    hi  = acc_max(w_acc);
    lo  = acc_min(w_acc);
    sat = 1'b0;
    if (sum > hi) begin
      sum = hi;
      sat = 1'b1;
    end else if (sum < lo) begin
      sum = lo;
      sat = 1'b1;
    end
    return sum;
  endfunction

endpackage

// File: rtl/neuron_mac_lane.sv
// One multiply-accumulate lane of the neuron layer.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : accepted start; loads bias, clears sat flag, latches relu_en
//   beat      : accepted pixel/weight beat; accumulates with saturation
//   last      : accepted final beat; registers the (optionally ReLU'd) result
//   relu_en   : ReLU enable, captured on load
//   bias      : signed initial accumulator value
//   pixel     : unsigned pixel shared by all lanes
//   weight    : signed weight for this lane
//   sigma     : registered result
//   sat_flag  : sticky clamp indicator for the current/last inference
module neuron_mac_lane
  import neuron_pkg::*;
#(
  parameter int unsigned W_WEIGHT = 32,
  parameter int unsigned W_PIXEL  = 8,
  parameter int unsigned W_ACC    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                beat,
  input  logic                last,
  input  logic                relu_en,
  input  logic [W_ACC-1:0]    bias,
  input  logic [W_PIXEL-1:0]  pixel,
  input  logic [W_WEIGHT-1:0] weight,
  output logic [W_ACC-1:0]    sigma,
  output logic                sat_flag
);

  localparam int unsigned W_PROD = W_WEIGHT + W_PIXEL + 1;

  logic signed [W_ACC-1:0]  acc_q, acc_d;
  logic signed [W_ACC-1:0]  sigma_q, sigma_d;
  logic                     sat_q, sat_d;
  logic                     relu_q, relu_d;

  logic signed [W_PROD-1:0] w_ext;
  logic signed [W_PROD-1:0] p_ext;
  logic signed [W_PROD-1:0] prod;
  logic signed [W_ACC-1:0]  acc_next;
  logic                     clamp;

  always_comb begin
    // Pixel is zero-extended so the signed product stays exact at W_PROD bits.
    w_ext    = W_PROD'($signed(weight));
    p_ext    = W_PROD'($signed({1'b0, pixel}));
    prod     = w_ext * p_ext;
    acc_next = W_ACC'(sat_add(wide_t'(acc_q), wide_t'(prod), W_ACC, clamp));

    acc_d   = acc_q;
    sat_d   = sat_q;
    relu_d  = relu_q;
    sigma_d = sigma_q;
    if (load) begin
      acc_d  = bias;
      sat_d  = 1'b0;
      relu_d = relu_en;
    end else if (beat) begin
      acc_d = acc_next;
      sat_d = sat_q | clamp;
      if (last) begin
        sigma_d = (relu_q && acc_next[W_ACC-1]) ? '0 : acc_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      sat_q   <= 1'b0;
      relu_q  <= 1'b0;
      sigma_q <= '0;
    end else begin
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      relu_q  <= relu_d;
      sigma_q <= sigma_d;
    end
  end

  assign sigma    = sigma_q;
  assign sat_flag = sat_q;

endmodule

// File: rtl/neuron_layer.sv
// Layer of NUM_NEURONS parallel MAC lanes fed by one pixel stream.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin an inference (IDLE only); samples bias_in and relu_en
//   bias_in   : per-lane signed bias, lane i at [i*W_ACC +: W_ACC]
//   relu_en   : ReLU enable for the inference
//   in_valid / in_ready : pixel/weights beat handshake
//   pixel     : unsigned pixel shared by all lanes
//   weights   : per-lane signed weights, lane i at [i*W_WEIGHT +: W_WEIGHT]
//   out_valid / out_ready : result handshake
//   sigma     : per-lane signed result vector
//   sat_flag  : per-lane sticky saturation flags
//   busy      : any state other than IDLE
module neuron_layer
  import neuron_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned N_INPUTS    = 49,
  parameter int unsigned W_WEIGHT    = 32,
  parameter int unsigned W_PIXEL     = 8,
  parameter int unsigned W_ACC       = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_NEURONS*W_ACC-1:0]    bias_in,
  input  logic                            relu_en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [W_PIXEL-1:0]              pixel,
  input  logic [NUM_NEURONS*W_WEIGHT-1:0] weights,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*W_ACC-1:0]    sigma,
  output logic [NUM_NEURONS-1:0]          sat_flag,
  output logic                            busy
);

  localparam int unsigned CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start_acc;
  logic            beat;
  logic            last_beat;

  // Handshake decodes come straight from the state register.
  always_comb begin
    start_acc = (state_q == S_IDLE) && start;
    beat      = (state_q == S_ACCUM) && in_valid;
    last_beat = beat && (cnt_q == CW'(N_INPUTS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)     state_d = S_ACCUM;
      S_ACCUM:  if (last_beat) state_d = S_RESULT;
      S_RESULT: if (out_ready) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_acc || last_beat) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    out_valid = (state_q == S_RESULT);
    busy      = (state_q != S_IDLE);
  end

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
    neuron_mac_lane #(
      .W_WEIGHT (W_WEIGHT),
      .W_PIXEL  (W_PIXEL),
      .W_ACC    (W_ACC)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (start_acc),
      .beat     (beat),
      .last     (last_beat),
      .relu_en  (relu_en),
      .bias     (bias_in[i*W_ACC +: W_ACC]),
      .pixel    (pixel),
      .weight   (weights[i*W_WEIGHT +: W_WEIGHT]),
      .sigma    (sigma[i*W_ACC +: W_ACC]),
      .sat_flag (sat_flag[i])
    );
  end

endmodule

// File: tb/tb_neuron_layer.sv
module tb_neuron_layer;

  localparam int NN = 4;
  localparam int NI = 49;

  logic         clk = 1'b0;
  logic         rst, start, relu_en, in_valid, out_ready;
  logic [127:0] bias_in, weights;
  logic [7:0]   pixel;
  logic         in_ready, out_valid, busy;
  logic [127:0] sigma;
  logic [3:0]   sat_flag;

  neuron_layer #(
    .NUM_NEURONS (NN),
    .N_INPUTS    (NI),
    .W_WEIGHT    (32),
    .W_PIXEL     (8),
    .W_ACC       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias_in   (bias_in),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixel     (pixel),
    .weights   (weights),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sigma     (sigma),
    .sat_flag  (sat_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] sigma;
    logic [3:0]   sat;
  } exp_t;

  typedef struct {
    string        name;
    logic [127:0] bias;
    logic [127:0] wt;
    logic [7:0]   pix;
    logic         relu;
    bit           gaps;
    bit           poke;
    bit           stall;
    logic [127:0] exp_sigma;
    logic [3:0]   exp_sat;
  } row_t;

  row_t         rows [5];
  exp_t         exp_q [$];
  logic [7:0]   pix_arr [NI];
  logic [127:0] wt_arr  [NI];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [127:0] bias, input logic relu);
    exp_t   e;
    longint acc;
    longint hi = 64'sd2147483647;
    longint lo = -64'sd2147483648;
    e.sigma = '0;
    e.sat   = '0;
    for (int i = 0; i < NN; i++) begin
      acc = longint'($signed(bias[i*32 +: 32]));
      for (int b = 0; b < NI; b++) begin
        acc += longint'($signed(wt_arr[b][i*32 +: 32])) * longint'({56'd0, pix_arr[b]});
        if (acc > hi) begin acc = hi; e.sat[i] = 1'b1; end
        else if (acc < lo) begin acc = lo; e.sat[i] = 1'b1; end
      end
      if (relu && acc < 0) acc = 0;
      e.sigma[i*32 +: 32] = acc[31:0];
    end
    return e;
  endfunction

  task automatic fill_const(input logic [7:0] p, input logic [127:0] w);
    for (int b = 0; b < NI; b++) begin
      pix_arr[b] = p;
      wt_arr[b]  = w;
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the DUT idle.
  task automatic run_inf(input string name, input logic [127:0] bias, input logic relu,
                         input bit gaps, input int abort_at, input bit poke,
                         input bit stall, input bit hs_start);
    exp_t e;
    e.sigma = '0;
    e.sat   = '0;
    start   = 1'b1;
    bias_in = bias;
    relu_en = relu;
    @(negedge clk);
    start   = 1'b0;
    bias_in = {$urandom, $urandom, $urandom, $urandom};
    relu_en = ~relu;
    check({name, "_in_ready_after_start"}, {127'd0, in_ready}, 128'd1);
    for (int b = 0; b < NI; b++) begin
      if (b == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check({name, "_rst_outs"}, {125'd0, in_ready, out_valid, busy}, 128'd0);
        check({name, "_rst_sigma"}, sigma, 128'd0);
        check({name, "_rst_sat"}, {124'd0, sat_flag}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        return;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          pixel    = 8'($urandom);
          weights  = {$urandom, $urandom, $urandom, $urandom};
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      pixel    = pix_arr[b];
      weights  = wt_arr[b];
      if (poke && b == 10) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (b == NI - 2) check({name, "_no_early_valid"}, {127'd0, out_valid}, 128'd0);
    end
    in_valid = 1'b0;
    check({name, "_valid_latency"}, {127'd0, out_valid}, 128'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_sigma"}, sigma, e.sigma);
      check({name, "_sat"}, {124'd0, sat_flag}, {124'd0, e.sat});
    end
    if (stall) begin
      repeat (10) begin
        in_valid = 1'b1;
        start    = 1'b1;
        pixel    = 8'($urandom);
        @(negedge clk);
        check({name, "_stall_sigma"}, sigma, e.sigma);
        check({name, "_stall_valid"}, {127'd0, out_valid}, 128'd1);
      end
      in_valid = 1'b0;
      start    = 1'b0;
    end
    out_ready = 1'b1;
    start     = hs_start;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check({name, "_post_hs_state"}, {126'd0, out_valid, busy}, 128'd0);
    check({name, "_post_hs_hold"}, sigma, e.sigma);
  endtask

  task automatic run_row(input int idx, input int abort_at, input bit hs_start);
    exp_t e;
    fill_const(rows[idx].pix, rows[idx].wt);
    e.sigma = rows[idx].exp_sigma;
    e.sat   = rows[idx].exp_sat;
    exp_q.push_back(e);
    run_inf(rows[idx].name, rows[idx].bias, rows[idx].relu, rows[idx].gaps, abort_at,
            rows[idx].poke, rows[idx].stall, hs_start);
  endtask

  initial begin
    rows[0] = '{"basic", {32'd100, 32'd0, 32'hFFFF_FFFB, 32'd10},
                {32'd0, 32'hFFFF_FFFF, 32'd2, 32'd1}, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1,
                {32'd100, 32'hFFFF_FFCF, 32'd93, 32'd59}, 4'b0000};
    rows[1] = '{"relu", {32'd100, 32'd0, 32'hFFFF_FFFB, 32'd10},
                {32'd0, 32'hFFFF_FFFF, 32'd2, 32'd1}, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0,
                {32'd100, 32'd0, 32'd93, 32'd59}, 4'b0000};
    rows[2] = '{"gaps", {32'd100, 32'd0, 32'hFFFF_FFFB, 32'd10},
                {32'd0, 32'hFFFF_FFFF, 32'd2, 32'd1}, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0,
                {32'd100, 32'hFFFF_FFCF, 32'd93, 32'd59}, 4'b0000};
    rows[3] = '{"pos_sat", {4{32'h7FFF_FF00}}, {4{32'h7FFF_FFFF}}, 8'd255,
                1'b0, 1'b0, 1'b0, 1'b0, {4{32'h7FFF_FFFF}}, 4'b1111};
    rows[4] = '{"neg_sat", {32'd5, {3{32'h8000_0100}}}, {32'd0, {3{32'h8000_0000}}}, 8'd255,
                1'b0, 1'b0, 1'b0, 1'b0, {32'd5, {3{32'h8000_0000}}}, 4'b0111};

    rst = 1'b0; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias_in = '0; weights = '0; pixel = '0;

    #2 rst = 1'b1;
    #1;
    check("reset_ctrl", {125'd0, in_ready, out_valid, busy}, 128'd0);
    check("reset_sigma", sigma, 128'd0);
    check("reset_sat", {124'd0, sat_flag}, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Beats offered while idle must be ignored.
    repeat (3) begin
      in_valid = 1'b1;
      pixel    = 8'd255;
      weights  = '1;
      @(negedge clk);
      check("idle_ignores_beat", {126'd0, busy, in_ready}, 128'd0);
    end
    in_valid = 1'b0;

    for (int r = 0; r < 5; r++) run_row(r, -1, 1'b0);

    // Start coincident with the handshake is dropped; the next cycle's start is taken.
    run_row(3, -1, 1'b1);
    run_row(0, -1, 1'b0);

    // Reset in the middle of a saturating run, then a clean run.
    run_row(3, 20, 1'b0);
    check("after_abort_idle", {127'd0, busy}, 128'd0);
    run_row(0, -1, 1'b0);

    for (int k = 0; k < 2; k++) begin
      exp_t       e;
      logic [127:0] bias;
      logic       relu;
      for (int b = 0; b < NI; b++) begin
        pix_arr[b] = 8'($urandom);
        for (int i = 0; i < NN; i++)
          wt_arr[b][i*32 +: 32] = (k == 0) ? 32'($urandom_range(0, 2000)) - 32'd1000 : $urandom;
      end
      bias = {$urandom, $urandom, $urandom, $urandom};
      relu = 1'($urandom);
      e    = model(bias, relu);
      exp_q.push_back(e);
      run_inf((k == 0) ? "rand_small" : "rand_full", bias, relu, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
